// File: rtl/sm3_pkg.sv
// Shared SM3 constants, FSM state type and the XOR/rotate helpers used by
// the message expander.
package sm3_pkg;

  localparam int SM3_WORD_W    = 32;
  localparam int SM3_BLK_WORDS = 16;
  localparam int SM3_ROUNDS    = 64;

  typedef logic [SM3_WORD_W-1:0] word_t;

  typedef enum logic {
    LOAD = 1'b0,
    EXPD = 1'b1
  } state_t;

  // 32-bit rotate left; n is always a small constant in this design
  function automatic word_t rotl(input word_t x, input int n);
    return (x << n) | (x >> (SM3_WORD_W - n));
  endfunction

  // SM3 message-expansion permutation
  function automatic word_t p1(input word_t x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

endpackage

// File: rtl/sm3_expnd_wgen.sv
// Combinational next-word generator: given window words W_j, W_j+3, W_j+7,
// W_j+10 and W_j+13 it produces W_j+16.
import sm3_pkg::*;

module sm3_expnd_wgen (
  input  word_t w0,
  input  word_t w3,
  input  word_t w7,
  input  word_t w10,
  input  word_t w13,
  output word_t w16
);

  // W_j+16 = P1(W_j ^ W_j+7 ^ rotl(W_j+13,15)) ^ rotl(W_j+3,7) ^ W_j+10
  always_comb begin
    w16 = p1(w0 ^ w7 ^ rotl(w13, 15)) ^ rotl(w3, 7) ^ w10;
  end

endmodule

// File: rtl/sm3_expnd.sv
// SM3 message expander. Loads a 16-word block into a sliding window, then
// emits W_j and W'_j = W_j ^ W_j+4 for j = 0..63, one pair per cycle.
//
// Handshake: a word is transferred on a rising edge where pad_otpt_ena and
// pad_otpt_vld are both high; ena depends only on the state register, and
// the output side (expnd_otpt_vld) has no backpressure.
//
// Output timing: outputs are registered and present W_j during the EXPD
// cycle whose round counter equals j. To achieve that, each edge loads the
// output registers from window slot 1 (the word that becomes slot 0 after the
// window shift on that same edge), so the first pair appears in the cycle
// right after the 16th-word handshake.
import sm3_pkg::*;

module sm3_expnd (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SM3_WORD_W-1:0] pad_otpt_d,
  input  logic                  pad_otpt_vld,
  input  logic                  pad_otpt_lst,
  output logic                  pad_otpt_ena,
  output logic [SM3_WORD_W-1:0] expnd_otpt_wj,
  output logic [SM3_WORD_W-1:0] expnd_otpt_wjj,
  output logic                  expnd_otpt_vld,
  output logic                  expnd_otpt_lst
);

  // FSM state is a plain named register so checkers can bind to it
  state_t     state;
  word_t      win [SM3_BLK_WORDS];
  logic [3:0] load_cnt;
  logic [5:0] j;
  logic       lst_flag;
  word_t      w_next;
  logic       hs;

  assign pad_otpt_ena = (state == LOAD);
  assign hs           = pad_otpt_ena && pad_otpt_vld;

  sm3_expnd_wgen u_wgen (
    .w0  (win[0]),
    .w3  (win[3]),
    .w7  (win[7]),
    .w10 (win[10]),
    .w13 (win[13]),
    .w16 (w_next)
  );

  // Control FSM, window shift register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= LOAD;
      load_cnt       <= 4'd0;
      j              <= 6'd0;
      lst_flag       <= 1'b0;
      for (int i = 0; i < SM3_BLK_WORDS; i++) win[i] <= '0;
      expnd_otpt_wj  <= '0;
      expnd_otpt_wjj <= '0;
      expnd_otpt_vld <= 1'b0;
      expnd_otpt_lst <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (hs) begin
            for (int i = 0; i < SM3_BLK_WORDS - 1; i++) win[i] <= win[i+1];
            win[SM3_BLK_WORDS-1] <= pad_otpt_d;
            if (load_cnt == 4'd15) begin
              // 16th word: block complete, W_0 = slot 1 before this shift
              load_cnt       <= 4'd0;
              lst_flag       <= pad_otpt_lst;
              state          <= EXPD;
              j              <= 6'd0;
              expnd_otpt_wj  <= win[1];
              expnd_otpt_wjj <= win[1] ^ win[5];
              expnd_otpt_vld <= 1'b1;
              expnd_otpt_lst <= 1'b0;
            end else begin
              load_cnt <= load_cnt + 4'd1;
            end
          end
        end
        EXPD: begin
          for (int i = 0; i < SM3_BLK_WORDS - 1; i++) win[i] <= win[i+1];
          win[SM3_BLK_WORDS-1] <= w_next;
          if (j == 6'd63) begin
            state          <= LOAD;
            j              <= 6'd0;
            lst_flag       <= 1'b0;
            expnd_otpt_vld <= 1'b0;
            expnd_otpt_lst <= 1'b0;
          end else begin
            j              <= j + 6'd1;
            expnd_otpt_wj  <= win[1];
            expnd_otpt_wjj <= win[1] ^ win[5];
            expnd_otpt_lst <= lst_flag && (j == 6'd62);
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sm3_expnd.sv
// Bench for sm3_expnd: directed blocks, a reference expansion feeding an
// expected queue, and a negedge monitor that pops and compares each output.
module tb_sm3_expnd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pad_otpt_d;
  logic        pad_otpt_vld;
  logic        pad_otpt_lst;
  logic        pad_otpt_ena;
  logic [31:0] expnd_otpt_wj;
  logic [31:0] expnd_otpt_wjj;
  logic        expnd_otpt_vld;
  logic        expnd_otpt_lst;

  sm3_expnd dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pad_otpt_d     (pad_otpt_d),
    .pad_otpt_vld   (pad_otpt_vld),
    .pad_otpt_lst   (pad_otpt_lst),
    .pad_otpt_ena   (pad_otpt_ena),
    .expnd_otpt_wj  (expnd_otpt_wj),
    .expnd_otpt_wjj (expnd_otpt_wjj),
    .expnd_otpt_vld (expnd_otpt_vld),
    .expnd_otpt_lst (expnd_otpt_lst)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_bad = 0;
  logic [64:0] exp_q [$];
  logic [64:0] mon_e;
  int          vld_cnt = 0;
  int          ena_low = 0;
  int          lst_cnt = 0;
  logic [31:0] cap_wj  [128];
  logic [31:0] cap_wjj [128];
  logic        cap_lst [128];
  logic [31:0] abc_blk [16];
  logic [31:0] rnd_blk [16];

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  endtask

  // ---------------- reference expansion ----------------
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] perm1(input logic [31:0] x);
    return x ^ rl(x, 15) ^ rl(x, 23);
  endfunction

  function automatic void push_model(input logic [31:0] blk [16], input logic lst);
    logic [31:0] w [68];
    for (int k = 0; k < 16; k++) w[k] = blk[k];
    for (int n = 16; n < 68; n++)
      w[n] = perm1(w[n-16] ^ w[n-9] ^ rl(w[n-3], 15)) ^ rl(w[n-13], 7) ^ w[n-6];
    for (int k = 0; k < 64; k++)
      exp_q.push_back({(lst && (k == 63)), w[k], w[k] ^ w[k+4]});
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (!pad_otpt_ena) ena_low++;
      if (expnd_otpt_lst) lst_cnt++;
      if (expnd_otpt_vld) begin
        if (vld_cnt < 128) begin
          cap_wj[vld_cnt]  = expnd_otpt_wj;
          cap_wjj[vld_cnt] = expnd_otpt_wjj;
          cap_lst[vld_cnt] = expnd_otpt_lst;
        end
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_out: got wj=%h wjj=%h lst=%b with nothing expected",
                   expnd_otpt_wj, expnd_otpt_wjj, expnd_otpt_lst);
        end else begin
          mon_e = exp_q.pop_front();
          check("lst_wj_wjj", {expnd_otpt_lst, expnd_otpt_wj, expnd_otpt_wjj}, mon_e);
        end
        vld_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    vld_cnt = 0;
    ena_low = 0;
    lst_cnt = 0;
    for (int i = 0; i < 128; i++) begin
      cap_wj[i] = '0; cap_wjj[i] = '0; cap_lst[i] = 1'b0;
    end
  endtask

  task automatic send_block(input logic [31:0] blk [16], input logic lst16,
                            input logic lst5, input bit toggle);
    int  budget;
    bit  done;
    push_model(blk, lst16);
    for (int k = 0; k < 16; k++) begin
      if (toggle && (k % 2 == 1)) begin
        @(negedge clk);
        pad_otpt_vld = 1'b0;
        pad_otpt_lst = 1'b0;
      end
      budget = 0;
      done   = 1'b0;
      while (!done) begin
        @(negedge clk);
        pad_otpt_d   = blk[k];
        pad_otpt_vld = 1'b1;
        pad_otpt_lst = (k == 15) ? lst16 : ((k == 4) ? lst5 : 1'b0);
        if (pad_otpt_ena) begin
          @(posedge clk);
          done = 1'b1;
        end else begin
          budget++;
          if (budget > 300) begin
            n_vec++;
            n_bad++;
            $display("FAIL ena_timeout: word %0d not accepted within 300 cycles", k);
            finish_run();
          end
        end
      end
    end
    #1;
    check("first_vld", 65'(expnd_otpt_vld), 65'd1);
    check("ena_drop", 65'(pad_otpt_ena), 65'd0);
    @(negedge clk);
    pad_otpt_vld = 1'b0;
    pad_otpt_lst = 1'b0;
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 500) begin
      @(posedge clk);
      b++;
    end
    check("drain", 65'(exp_q.size()), 65'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_abc();
    check("abc_w0",   65'(cap_wj[0]),  65'h61626380);
    check("abc_wp0",  65'(cap_wjj[0]), 65'h61626380);
    check("abc_w16",  65'(cap_wj[16]), 65'h9092e200);
    check("abc_w18",  65'(cap_wj[18]), 65'h000c0606);
    check("abc_w19",  65'(cap_wj[19]), 65'h719c70ed);
    check("abc_lst63", 65'(cap_lst[63]), 65'd1);
    check("abc_lst_cnt", 65'(lst_cnt), 65'd1);
    check("abc_vld_cnt", 65'(vld_cnt), 65'd64);
    check("abc_ena_low", 65'(ena_low), 65'd64);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int b;
    for (int k = 0; k < 16; k++) abc_blk[k] = 32'h0;
    abc_blk[0]  = 32'h61626380;
    abc_blk[15] = 32'h00000018;

    rst_n        = 1'b0;
    pad_otpt_d   = '0;
    pad_otpt_vld = 1'b0;
    pad_otpt_lst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", 65'(expnd_otpt_vld), 65'd0);
    check("rst_lst", 65'(expnd_otpt_lst), 65'd0);
    check("rst_wj",  65'(expnd_otpt_wj),  65'd0);
    check("rst_wjj", 65'(expnd_otpt_wjj), 65'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ena", 65'(pad_otpt_ena), 65'd1);

    // "abc" block, final
    clear_counts();
    send_block(abc_blk, 1'b1, 1'b0, 1'b0);
    wait_drain();
    check_abc();

    // same block, valid toggling every other cycle
    clear_counts();
    send_block(abc_blk, 1'b1, 1'b0, 1'b1);
    wait_drain();
    check_abc();

    // two back-to-back blocks, lst only on the second
    clear_counts();
    for (int k = 0; k < 16; k++) rnd_blk[k] = $urandom;
    send_block(rnd_blk, 1'b0, 1'b0, 1'b0);
    send_block(abc_blk, 1'b1, 1'b0, 1'b0);
    wait_drain();
    check("b2b_vld_cnt", 65'(vld_cnt), 65'd128);
    check("b2b_ena_low", 65'(ena_low), 65'd128);
    check("b2b_lst_cnt", 65'(lst_cnt), 65'd1);
    check("b2b_lst128", 65'(cap_lst[127]), 65'd1);

    // lst on word 5 only must be ignored
    clear_counts();
    send_block(abc_blk, 1'b0, 1'b1, 1'b0);
    wait_drain();
    check("w5lst_lst_cnt", 65'(lst_cnt), 65'd0);

    // reset in the middle of expansion
    clear_counts();
    send_block(abc_blk, 1'b1, 1'b0, 1'b0);
    b = 0;
    while (vld_cnt < 31 && b < 200) begin
      @(posedge clk);
      #1;
      b++;
    end
    check("reach_j30", 65'(vld_cnt >= 31), 65'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 65'(expnd_otpt_vld), 65'd0);
    check("mid_rst_lst", 65'(expnd_otpt_lst), 65'd0);
    check("mid_rst_wj",  65'(expnd_otpt_wj),  65'd0);
    check("mid_rst_wjj", 65'(expnd_otpt_wjj), 65'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ena", 65'(pad_otpt_ena), 65'd1);
    clear_counts();
    send_block(abc_blk, 1'b1, 1'b0, 1'b0);
    wait_drain();
    check_abc();

    // random blocks against the reference expansion
    for (int r = 0; r < 3; r++) begin
      clear_counts();
      for (int k = 0; k < 16; k++) rnd_blk[k] = $urandom;
      send_block(rnd_blk, 1'($urandom_range(0, 1)), 1'b0, 1'(r == 1));
      wait_drain();
      check("rnd_vld_cnt", 65'(vld_cnt), 65'd64);
    end

    finish_run();
  end

endmodule

// File: doc/sm3_expnd.md
SM3_EXPND -- requirements
Module: sm3_expnd

Interface
REQ-001 Parameters: none; word width fixed at 32 bits by shared package constant SM3_WORD_W = 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 pad_otpt_d  input  32  padded message word, big-endian word order within 512-bit block.
REQ-005 pad_otpt_vld  input  1  pad_otpt_d valid.
REQ-006 pad_otpt_lst  input  1  word belongs to final block of message; sampled on 16th word only.
REQ-007 pad_otpt_ena  output  1  expander ready to accept a word; handshake = pad_otpt_ena && pad_otpt_vld.
REQ-008 expnd_otpt_wj  output  32  W_j, j = 0..63.
REQ-009 expnd_otpt_wjj  output  32  W'_j = W_j ^ W_(j+4).
REQ-010 expnd_otpt_vld  output  1  wj/wjj valid; no downstream backpressure exists.
REQ-011 expnd_otpt_lst  output  1  high with j = 63 of the final block of a message.

Function
REQ-012 FSM states: LOAD, EXPD; reset state LOAD.
REQ-013 pad_otpt_ena SHALL be 1 exactly when state == LOAD (decoded from state register, no input path).
REQ-014 LOAD: each handshake shifts pad_otpt_d into a 16 x 32-bit window (word 0 oldest) and increments 4-bit load counter; no handshake -> window and counter hold.
REQ-015 On the handshake of the 16th word: capture pad_otpt_lst into lst_flag, clear counter, go to EXPD next cycle.
REQ-016 pad_otpt_lst on words 1..15 SHALL be ignored.
REQ-017 EXPD: 6-bit round counter j runs 0..63, one output per cycle, expnd_otpt_vld = 1 every EXPD cycle.
REQ-018 Per EXPD cycle: wj = win[0], wjj = win[0] ^ win[4]; window shifts by one, new win[15] = P1(win[0] ^ win[7] ^ rotl(win[13],15)) ^ rotl(win[3],7) ^ win[10].
REQ-019 P1(x) = x ^ rotl(x,15) ^ rotl(x,23); all arithmetic 32-bit XOR/rotate, no carries.
REQ-020 Outputs SHALL be registered; first vld (j = 0) in the cycle after the 16th-word handshake edge.
REQ-021 expnd_otpt_lst = lst_flag && (j == 63); 0 otherwise.
REQ-022 After j = 63: return to LOAD next cycle, vld = 0, lst_flag cleared; pad_otpt_ena = 1 in that cycle.
REQ-023 pad_otpt_vld during EXPD SHALL be ignored (ena = 0, upstream holds data).
REQ-024 Minimum block period: 16 load cycles + 64 expand cycles = 80 cycles; blocks back-to-back without extra idle.
REQ-025 When not in EXPD: vld = 0, lst = 0, wj/wjj hold last value.

Reset
REQ-026 rst_n low asynchronously forces state = LOAD, load counter = 0, j = 0, lst_flag = 0, window = 0, expnd_otpt_wj = 0, expnd_otpt_wjj = 0, expnd_otpt_vld = 0, expnd_otpt_lst = 0.
REQ-027 Reset mid-LOAD or mid-EXPD discards the partial block; after release the next accepted word is word 0 of a new block.
REQ-028 pad_otpt_ena = 1 in the first cycle after rst_n deasserts.

Structure
REQ-029 Package sm3_pkg holds SM3_WORD_W, block word count 16, round count 64, FSM state enum, and rotl/P1 functions.
REQ-030 One sub-module sm3_expnd_wgen: combinational next-word generator (five window words in, W_(j+16) out); FSM, counters, window in sm3_expnd.

Verification
REQ-031 "abc" padded block (61626380, 0 x14, 00000018) with lst = 1 on word 16 -> j = 0: wj = 61626380, wjj = 61626380; j = 16: wj = 9092e200; j = 18: wj = 000c0606; j = 19: wj = 719c70ed; lst = 1 only at j = 63.
REQ-032 Same block with pad_otpt_vld toggling every other cycle -> identical W/W' sequence; first vld one cycle after the 16th handshake.
REQ-033 Two back-to-back blocks, lst = 0 then 1 -> 128 vld cycles, ena = 0 for exactly 64 cycles per block, lst only on 128th output.
REQ-034 pad_otpt_lst = 1 on word 5 and 0 on word 16 -> expnd_otpt_lst never asserts.
REQ-035 rst_n pulsed at j = 30 -> vld/lst/wj/wjj = 0 immediately, ena = 1 after release, fresh block reproduces REQ-031 values.
REQ-036 Random blocks vs. reference model: every wj/wjj matches; vld count per block = 64.
